// File: rtl/afe_config_sequencer.sv
// AFE configuration sequencer: walks the command ROM from address 0 and runs
// 3-wire serial register writes, delays and an end marker.
module afe_config_sequencer #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned GAP_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [7:0]  rom_address,
   input  logic [23:0] rom_command,
   output logic        spi_sclk,
   output logic        spi_sen_n,
   output logic        spi_sdata,
   output logic        busy,
   output logic        done
);

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CMD_W  = 24;
   localparam int unsigned DIV_W  = 8;
   localparam int unsigned BIT_W  = 5;
   localparam int unsigned DLY_W  = 16;
   localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
   localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(CMD_W - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(255);
   localparam logic [7:0]        OP_END    = 8'hFF;
   localparam logic [7:0]        OP_DELAY  = 8'hFE;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_WAIT   = 4'd2;
   localparam logic [3:0] S_DECODE = 4'd3;
   localparam logic [3:0] S_SHIFT  = 4'd4;
   localparam logic [3:0] S_HOLD   = 4'd5;
   localparam logic [3:0] S_GAP    = 4'd6;
   localparam logic [3:0] S_DELAY  = 4'd7;
   localparam logic [3:0] S_DONE   = 4'd8;

   logic [3:0]        state, state_d;
   logic [ADDR_W-1:0] addr_d;
   logic              sclk_d, sen_n_d, sdata_d, busy_d, done_d;
   logic [CMD_W-1:0]  shreg, shreg_d;
   logic [DIV_W-1:0]  div_cnt, div_d;
   logic [BIT_W-1:0]  bit_cnt, bit_d;
   logic [GAP_W-1:0]  gap_cnt, gap_d;
   logic [DLY_W-1:0]  dly_cnt, dly_d;
   logic              ready;
   logic              advance;

   // ready blocks a start sampled on the first edge after reset release
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         rom_address <= '0;
         spi_sclk    <= 1'b0;
         spi_sen_n   <= 1'b1;
         spi_sdata   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         shreg       <= '0;
         div_cnt     <= '0;
         bit_cnt     <= '0;
         gap_cnt     <= '0;
         dly_cnt     <= '0;
         ready       <= 1'b0;
      end else begin
         state       <= state_d;
         rom_address <= addr_d;
         spi_sclk    <= sclk_d;
         spi_sen_n   <= sen_n_d;
         spi_sdata   <= sdata_d;
         busy        <= busy_d;
         done        <= done_d;
         shreg       <= shreg_d;
         div_cnt     <= div_d;
         bit_cnt     <= bit_d;
         gap_cnt     <= gap_d;
         dly_cnt     <= dly_d;
         ready       <= 1'b1;
      end
   end

   // Next-state and next-output logic; every output is the registered copy.
   always_comb begin
      state_d = state;
      addr_d  = rom_address;
      sclk_d  = spi_sclk;
      sen_n_d = spi_sen_n;
      sdata_d = spi_sdata;
      busy_d  = busy;
      done_d  = done;
      shreg_d = shreg;
      div_d   = div_cnt;
      bit_d   = bit_cnt;
      gap_d   = gap_cnt;
      dly_d   = dly_cnt;
      advance = 1'b0;

      case (state)
         S_IDLE, S_DONE: begin
            if (start && ready) begin
               state_d = S_FETCH;
               addr_d  = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         S_FETCH: state_d = S_WAIT;
         S_WAIT:  state_d = S_DECODE;
         S_DECODE: begin
            shreg_d = rom_command;
            if (rom_command[23:16] == OP_END) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (rom_command[23:16] == OP_DELAY) begin
               if (rom_command[15:0] == '0) begin
                  advance = 1'b1;
               end else begin
                  dly_d   = rom_command[15:0];
                  state_d = S_DELAY;
               end
            end else begin
               state_d = S_SHIFT;
               sen_n_d = 1'b0;
               sclk_d  = 1'b0;
               sdata_d = rom_command[CMD_W-1];
               div_d   = '0;
               bit_d   = BIT_FIRST;
            end
         end
         // Low half then high half of each bit; data moves on the falling edge
         S_SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               div_d = '0;
               if (!spi_sclk) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt == '0) begin
                     state_d = S_HOLD;
                  end else begin
                     bit_d   = bit_cnt - BIT_W'(1);
                     sdata_d = shreg[CMD_W-2];
                     shreg_d = {shreg[CMD_W-2:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_cnt + DIV_W'(1);
            end
         end
         S_HOLD: begin
            if (div_cnt == DIV_LAST) begin
               state_d = S_GAP;
               sen_n_d = 1'b1;
               sdata_d = 1'b0;
               gap_d   = '0;
            end else begin
               div_d = div_cnt + DIV_W'(1);
            end
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) advance = 1'b1;
            else                     gap_d   = gap_cnt + GAP_W'(1);
         end
         S_DELAY: begin
            if (dly_cnt == DLY_W'(1)) advance = 1'b1;
            else                      dly_d   = dly_cnt - DLY_W'(1);
         end
         default: state_d = S_IDLE;
      endcase

      // Step to the next command, stopping after the last ROM address
      if (advance) begin
         if (rom_address == ADDR_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end else begin
            addr_d  = rom_address + ADDR_W'(1);
            state_d = S_FETCH;
         end
      end
   end

endmodule

// File: tb/tb_afe_config_sequencer.sv
// Bench for afe_config_sequencer: two instances (CLK_DIV 4 and 1), a pin-level
// frame monitor, and a ROM-walk reference model.
module tb_afe_config_sequencer;

   localparam int unsigned GAP = 8;
   localparam int unsigned CD0 = 4;
   localparam int unsigned CD1 = 1;
   localparam int          TMO = 20000;

   logic clk = 1'b0;
   logic rst;
   logic [1:0] start, sclk, sen_n, sdata, busy, done;
   logic [1:0][7:0]  rom_address;
   logic [1:0][23:0] rom_command;
   logic [23:0] rom [2][256];
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   afe_config_sequencer #(.CLK_DIV(CD0), .GAP_CYCLES(GAP)) dut0 (
      .clk(clk), .reset(rst), .start(start[0]), .rom_address(rom_address[0]),
      .rom_command(rom_command[0]), .spi_sclk(sclk[0]), .spi_sen_n(sen_n[0]),
      .spi_sdata(sdata[0]), .busy(busy[0]), .done(done[0]));

   afe_config_sequencer #(.CLK_DIV(CD1), .GAP_CYCLES(GAP)) dut1 (
      .clk(clk), .reset(rst), .start(start[1]), .rom_address(rom_address[1]),
      .rom_command(rom_command[1]), .spi_sclk(sclk[1]), .spi_sen_n(sen_n[1]),
      .spi_sdata(sdata[1]), .busy(busy[1]), .done(done[1]));

   // Command ROM with one cycle registered read
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) rom_command[g] <= rom[g][rom_address[g]];
   end

   function automatic int cdiv(input int g);
      return (g == 0) ? int'(CD0) : int'(CD1);
   endfunction

   // Pin monitor: frames, bit capture on SCLK rise, edge spacing, idle levels
   int nfall[2], nfrm[2], bits[2], first_fall[2], last_rise[2], fall_c[2];
   int last_edge[2], min_gap[2], bad_frame[2], viol[2];
   logic [23:0] cap[2];
   logic [23:0] frm[2][260];
   logic [1:0] p_sen, p_sclk, p_sdata;
   logic mon_clr;

   initial begin
      p_sen = 2'b11; p_sclk = 2'b00; p_sdata = 2'b00;
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (mon_clr) begin
               nfall[g] = 0; nfrm[g] = 0; bits[g] = 0; first_fall[g] = -1;
               last_rise[g] = -1; fall_c[g] = 0; last_edge[g] = 0;
               min_gap[g] = 1 << 30; bad_frame[g] = 0; viol[g] = 0; cap[g] = '0;
            end else begin
               if (p_sen[g] && !sen_n[g]) begin
                  if (nfall[g] == 0) first_fall[g] = cyc;
                  if (last_rise[g] >= 0 && cyc - last_rise[g] < min_gap[g])
                     min_gap[g] = cyc - last_rise[g];
                  nfall[g]++; bits[g] = 0; cap[g] = '0;
                  fall_c[g] = cyc; last_edge[g] = cyc;
               end
               if (!sen_n[g] && sclk[g] != p_sclk[g]) begin
                  if (cyc - last_edge[g] != cdiv(g)) viol[g]++;
                  last_edge[g] = cyc;
                  if (sclk[g]) begin
                     cap[g] = {cap[g][22:0], sdata[g]};
                     bits[g]++;
                  end
               end
               if (sclk[g] && p_sclk[g] && sdata[g] != p_sdata[g]) viol[g]++;
               if (sen_n[g] && (sclk[g] || sdata[g])) viol[g]++;
               if (!p_sen[g] && sen_n[g]) begin
                  if (bits[g] != 24 || cyc - fall_c[g] != 49 * cdiv(g) ||
                      cyc - last_edge[g] != cdiv(g)) bad_frame[g]++;
                  if (nfrm[g] < 260) frm[g][nfrm[g]] = cap[g];
                  nfrm[g]++;
                  last_rise[g] = cyc;
               end
            end
         end
         p_sen = sen_n; p_sclk = sclk; p_sdata = sdata;
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: walk the ROM, collect writes in order, find where it stops
   logic [23:0] exp_q[$];
   int exp_last;

   task automatic build_model(input int g);
      exp_q.delete();
      exp_last = 255;
      for (int a = 0; a < 256; a++) begin
         logic [7:0] op;
         op = rom[g][a][23:16];
         if (op == 8'hFF) begin
            exp_last = a;
            break;
         end
         if (op != 8'hFE) exp_q.push_back(rom[g][a]);
      end
   endtask

   task automatic fill_end(input int g);
      for (int a = 0; a < 256; a++) rom[g][a] = 24'hFF0000;
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   int run_sc;

   task automatic run_seq(input int g, input string tag, input bit poke);
      int t;
      int pokes;
      t = 0;
      pokes = 0;
      build_model(g);
      clear_mon();
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
      run_sc = cyc;
      check({tag, "_accept"}, 32'({busy[g], done[g]}), 32'(2'b10));
      while (done[g] !== 1'b1 && t < TMO) begin
         @(negedge clk);
         t++;
         if (poke && !sen_n[g] && pokes < 3) begin
            start[g] = 1'b1;
            @(negedge clk);
            start[g] = 1'b0;
            t++;
            pokes++;
         end
      end
      check({tag, "_finish"}, 32'(t < TMO), 32'd1);
      repeat (2) @(negedge clk);
      check({tag, "_nframes"}, 32'(nfrm[g]), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < nfrm[g] && i < 260; i++)
         check($sformatf("%s_frame%0d", tag, i), 32'(frm[g][i]), 32'(exp_q[i]));
      check({tag, "_shape"}, 32'(bad_frame[g]), 32'd0);
      check({tag, "_pins"}, 32'(viol[g]), 32'd0);
      if (exp_q.size() > 1)
         check({tag, "_gap"}, 32'(min_gap[g] >= int'(GAP) + 3), 32'd1);
      if (rom[g][0][23:16] < 8'hFE)
         check({tag, "_latency"}, 32'(first_fall[g] - run_sc), 32'd3);
      check({tag, "_end"}, 32'({rom_address[g], busy[g], done[g], sen_n[g], sclk[g]}),
            32'({8'(exp_last), 4'b0110}));
   endtask

   task automatic rand_rom(input int g, input int len);
      fill_end(g);
      for (int a = 0; a < len; a++) begin
         if ($urandom_range(0, 9) < 2)
            rom[g][a] = {8'hFE, 16'($urandom_range(0, 40))};
         else
            rom[g][a] = {8'($urandom_range(0, 253)), 16'($urandom)};
      end
   endtask

   initial begin
      int t;
      int n0;
      logic [3:0] dv;
      rst = 1'b1;
      start = 2'b00;
      mon_clr = 1'b1;
      fill_end(0);
      fill_end(1);
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++)
         check($sformatf("reset_state%0d", g),
               32'({rom_address[g], sclk[g], sen_n[g], sdata[g], busy[g], done[g]}),
               32'({8'h00, 5'b01000}));
      rst = 1'b0;
      mon_clr = 1'b0;
      repeat (2) @(negedge clk);

      // Single write then END
      rom[0][0] = 24'h0012AB;
      rom[0][1] = 24'hFF0000;
      run_seq(0, "t1", 1'b0);

      // Delay of 100 then a write
      fill_end(0);
      rom[0][0] = 24'hFE0064;
      rom[0][1] = 24'h01FFFF;
      run_seq(0, "t2", 1'b0);
      check("t2_delay", 32'((first_fall[0] - run_sc) >= 106 && (first_fall[0] - run_sc) <= 107), 32'd1);

      // END at address 0: done on the 4th cycle, bus untouched
      fill_end(0);
      clear_mon();
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         dv[i] = done[0];
      end
      check("t3_done_timing", 32'(dv), 32'(4'b1000));
      check("t3_end", 32'({rom_address[0], busy[0], nfall[0] == 0}), 32'({8'h00, 2'b01}));

      // 256 writes with no END on the CLK_DIV=1 instance
      for (int a = 0; a < 256; a++) rom[1][a] = {8'($urandom_range(0, 253)), 16'($urandom)};
      run_seq(1, "t4", 1'b0);
      n0 = nfall[1];
      repeat (200) @(negedge clk);
      check("t4_no_second_pass", 32'({nfall[1] == n0, done[1]}), 32'(2'b11));

      // start pulses during frames are ignored
      rand_rom(0, 5);
      run_seq(0, "t5", 1'b1);

      // Reset at bit 10 aborts at once; start at reset release is ignored
      rand_rom(0, 3);
      rom[0][0] = {8'h3C, 16'hA5F0};
      clear_mon();
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      t = 0;
      while (bits[0] < 10 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      check("t6_reach_bit10", 32'(t < 5000), 32'd1);
      #2 rst = 1'b1;
      #1 check("t6_async_abort", 32'({sen_n[0], sclk[0], sdata[0], busy[0], rom_address[0]}),
               32'({4'b1000, 8'h00}));
      @(negedge clk);
      rst = 1'b0;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_start_at_release", 32'({busy[0], sen_n[0], done[0]}), 32'(3'b010));
      run_seq(0, "t6_rerun", 1'b0);

      // Restart from DONE replays identically, on both clock dividers
      run_seq(0, "t7_replay0", 1'b0);
      rand_rom(1, 4);
      run_seq(1, "t7_first1", 1'b0);
      run_seq(1, "t7_replay1", 1'b0);

      // Randomized command sequences
      for (int r = 0; r < 8; r++) begin
         int g;
         g = r % 2;
         rand_rom(g, int'($urandom_range(1, 10)));
         run_seq(g, $sformatf("rnd%0d", r), 1'(($urandom_range(0, 3) == 0)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
